// File: rtl/mem_arbiter.sv
// Purpose : two-port (CPU / I/O) round-robin arbiter and handshake sequencer for the 31-bit word store.
// Latency : 3 cycles request-to-ack, 4 cycles per access; out-of-range (addr[11]=1) acks with err in 1 cycle.
// Backpr. : requesters hold req until ack; ACCESS waits for mem_finish (bounded only with MEM_ARBITER_TIMEOUT_EN).
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack/err/rdata   CPU port (level request, 1-cycle ack pulse)
//   io_req/we/addr/wdata  -> io_ack/err/rdata    I/O loader port, same protocol
//   mem_read_enable, mem_write_enable, mem_addr, mem_write_data   registered store controls
//   mem_read_data, mem_finish            store response (finish one cycle after enable is first seen)
//
// Optional feature macro: MEM_ARBITER_TIMEOUT_EN (aborts an ACCESS after TIMEOUT_CYCLES cycles).
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [30:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [30:0] cpu_rdata,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [11:0] io_addr,
  input  logic [30:0] io_wdata,
  output logic        io_ack,
  output logic        io_err,
  output logic [30:0] io_rdata,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [11:0] mem_addr,
  output logic [30:0] mem_write_data,
  input  logic [30:0] mem_read_data,
  input  logic        mem_finish
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        last_io_q, last_io_d;   // 1: I/O port was served last
  logic        sel_io_q, sel_io_d;     // winner of the access in flight
  logic        we_q, we_d;             // direction of the access in flight
  logic        mem_re_d, mem_we_d;
  logic [11:0] addr_d;
  logic [30:0] wdata_d;
  logic        cpu_ack_d, cpu_err_d, io_ack_d, io_err_d;
  logic [30:0] cpu_rdata_d, io_rdata_d;

  // Winner selection: on a tie, the port not served last gets the grant.
  logic        grant_io;
  logic        w_we;
  logic [11:0] w_addr;
  logic [30:0] w_wdata;

  assign grant_io = io_req && (!cpu_req || !last_io_q);
  assign w_we     = grant_io ? io_we    : cpu_we;
  assign w_addr   = grant_io ? io_addr  : cpu_addr;
  assign w_wdata  = grant_io ? io_wdata : cpu_wdata;

  logic tmo;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt_q, tcnt_d;
  // Fires during the last allowed ACCESS cycle so DONE follows exactly TIMEOUT_CYCLES ACCESS cycles.
  assign tmo = (tcnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      last_io_q        <= 1'b1;
      sel_io_q         <= 1'b0;
      we_q             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      cpu_ack          <= 1'b0;
      cpu_err          <= 1'b0;
      cpu_rdata        <= '0;
      io_ack           <= 1'b0;
      io_err           <= 1'b0;
      io_rdata         <= '0;
    end else begin
      state_q          <= state_d;
      last_io_q        <= last_io_d;
      sel_io_q         <= sel_io_d;
      we_q             <= we_d;
      mem_read_enable  <= mem_re_d;
      mem_write_enable <= mem_we_d;
      mem_addr         <= addr_d;
      mem_write_data   <= wdata_d;
      cpu_ack          <= cpu_ack_d;
      cpu_err          <= cpu_err_d;
      cpu_rdata        <= cpu_rdata_d;
      io_ack           <= io_ack_d;
      io_err           <= io_err_d;
      io_rdata         <= io_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_io_d   = last_io_q;
    sel_io_d    = sel_io_q;
    we_d        = we_q;
    mem_re_d    = mem_read_enable;
    mem_we_d    = mem_write_enable;
    addr_d      = mem_addr;
    wdata_d     = mem_write_data;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    io_ack_d    = 1'b0;
    io_err_d    = 1'b0;
    cpu_rdata_d = cpu_rdata;
    io_rdata_d  = io_rdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
    tcnt_d      = tcnt_q + 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (cpu_req || io_req) begin
          sel_io_d  = grant_io;
          last_io_d = grant_io;
          we_d      = w_we;
          addr_d    = w_addr;
          wdata_d   = w_wdata;
          if (w_addr[11]) begin
            // Upper half of the address space has no storage: answer with an error, store untouched.
            state_d = S_DONE;
            if (grant_io) begin
              io_ack_d = 1'b1;
              io_err_d = 1'b1;
              if (!w_we) io_rdata_d = '0;
            end else begin
              cpu_ack_d = 1'b1;
              cpu_err_d = 1'b1;
              if (!w_we) cpu_rdata_d = '0;
            end
          end else begin
            state_d  = S_ACCESS;
            mem_re_d = !w_we;
            mem_we_d = w_we;
`ifdef MEM_ARBITER_TIMEOUT_EN
            tcnt_d   = '0;
`endif
          end
        end
      end

      S_ACCESS: begin
        if (mem_finish || tmo) begin
          // Dropping the enables here guarantees the store sees at least one idle sample
          // (DONE and IDLE) before the next enable.
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_DONE;
          if (sel_io_q) begin
            io_ack_d = 1'b1;
            io_err_d = !mem_finish;
            if (!we_q) io_rdata_d = mem_finish ? mem_read_data : '0;
          end else begin
            cpu_ack_d = 1'b1;
            cpu_err_d = !mem_finish;
            if (!we_q) cpu_rdata_d = mem_finish ? mem_read_data : '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [30:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_err;
  logic [30:0] cpu_rdata;
  logic        io_req = 1'b0, io_we = 1'b0;
  logic [11:0] io_addr = '0;
  logic [30:0] io_wdata = '0;
  logic        io_ack, io_err;
  logic [30:0] io_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [11:0] mem_addr;
  logic [30:0] mem_write_data;
  logic [30:0] mem_read_data = '0;
  logic        mem_finish = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_err(io_err), .io_rdata(io_rdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_finish(mem_finish)
  );

  // Store model: finish one cycle after an enable is first seen, re-arms after an idle sample.
  // Unwritten words read back as {20'h5A5A5, addr[10:0]}.
  logic [30:0] store   [0:2047];
  bit          written [0:2047];
  logic        st_busy = 1'b0;
  logic        stall = 1'b0;

  always @(posedge clk) begin
    if ((mem_read_enable || mem_write_enable) && !stall) begin
      if (!st_busy) begin
        mem_finish <= 1'b1;
        st_busy    <= 1'b1;
        if (mem_write_enable) begin
          store[mem_addr[10:0]]   <= mem_write_data;
          written[mem_addr[10:0]] <= 1'b1;
        end
        mem_read_data <= written[mem_addr[10:0]] ? store[mem_addr[10:0]]
                                                 : {20'h5A5A5, mem_addr[10:0]};
      end else begin
        mem_finish <= 1'b0;
      end
    end else begin
      mem_finish <= 1'b0;
      st_busy    <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acks"}, {30'd0, cpu_ack, io_ack}, 32'd0);
    chk({tag, "_errs"}, {30'd0, cpu_err, io_err}, 32'd0);
    chk({tag, "_cpu_rdata"}, {1'b0, cpu_rdata}, 32'd0);
    chk({tag, "_io_rdata"}, {1'b0, io_rdata}, 32'd0);
    chk({tag, "_en"}, {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    chk({tag, "_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {1'b0, mem_write_data}, 32'd0);
  endtask

  // One access from an idle arbiter with only one port requesting.
  task automatic run_access(input string tag, input bit io, input bit we,
                            input logic [11:0] addr, input logic [30:0] wd,
                            input logic [30:0] exp_rd);
    bit oor;
    oor = addr[11];
    if (io) begin io_we = we; io_addr = addr; io_wdata = wd; io_req = 1'b1; end
    else    begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; end
    tick;
    if (!oor) begin
      chk({tag, "_en"}, {30'd0, mem_read_enable, mem_write_enable}, we ? 32'd1 : 32'd2);
      chk({tag, "_maddr"}, {20'd0, mem_addr}, {20'd0, addr});
      chk({tag, "_ack_early"}, {30'd0, cpu_ack, io_ack}, 32'd0);
      tick;
      tick;
    end else begin
      chk({tag, "_en_oor"}, {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    end
    chk({tag, "_ack"}, {30'd0, cpu_ack, io_ack}, io ? 32'd1 : 32'd2);
    chk({tag, "_err"}, {31'd0, io ? io_err : cpu_err}, {31'd0, oor});
    chk({tag, "_rdata"}, {1'b0, io ? io_rdata : cpu_rdata}, {1'b0, exp_rd});
    cpu_req = 1'b0;
    io_req  = 1'b0;
    tick;
    chk({tag, "_ack_end"}, {30'd0, cpu_ack, io_ack}, 32'd0);
  endtask

  task automatic do_reset;
    cpu_req = 1'b0;
    io_req  = 1'b0;
    resetn  = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
  endtask

  logic [30:0] exp_cpu, exp_io;
  int n;

  initial begin
    // Reset state.
    #1;
    chk_all_zero("reset");
    tick;
    resetn = 1'b1;

    // CPU write then read of the same word.
    run_access("cpu_wr", 1'b0, 1'b1, 12'o0123, 31'h12345678, 31'h0);
    run_access("cpu_rd", 1'b0, 1'b0, 12'o0123, 31'h0, 31'h12345678);

    // Both ports requesting reads from reset: CPU, I/O, CPU, I/O.
    do_reset;
    exp_cpu  = {20'h5A5A5, 11'o200};
    exp_io   = {20'h5A5A5, 11'o300};
    cpu_we   = 1'b0; cpu_addr = 12'o0200;
    io_we    = 1'b0; io_addr  = 12'o0300;
    cpu_req  = 1'b1; io_req   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("rr%0d_maddr", k), {20'd0, mem_addr}, k[0] ? 32'o0300 : 32'o0200);
      tick;
      tick;
      chk($sformatf("rr%0d_ack", k), {30'd0, cpu_ack, io_ack}, k[0] ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_rdata", k), {1'b0, k[0] ? io_rdata : cpu_rdata},
          {1'b0, k[0] ? exp_io : exp_cpu});
      if (k == 3) begin
        cpu_req = 1'b0;
        io_req  = 1'b0;
      end
      tick;
      chk($sformatf("rr%0d_gap", k), {30'd0, cpu_ack, io_ack}, 32'd0);
    end

    // Out-of-range I/O read: error ack one cycle after grant, rdata cleared.
    run_access("io_oor", 1'b1, 1'b0, 12'o4000, 31'h0, 31'h0);

    // Reset during ACCESS of a CPU write: everything drops asynchronously, no ack.
    cpu_we = 1'b1; cpu_addr = 12'o0055; cpu_wdata = 31'h0AAA5555; cpu_req = 1'b1;
    tick;
    chk("rst_mid_en", {31'd0, mem_write_enable}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("rst_async");
    tick;
    chk("rst_no_ack", {30'd0, cpu_ack, io_ack}, 32'd0);
    tick;
    cpu_req = 1'b0;
    resetn  = 1'b1;
    tick;
    run_access("rst_rewr", 1'b0, 1'b1, 12'o0055, 31'h0AAA5555, 31'h0);
    run_access("rst_rd", 1'b0, 1'b0, 12'o0055, 31'h0, 31'h0AAA5555);

    // I/O write then CPU read of the same word; I/O rdata survives the write.
    run_access("io_rd", 1'b1, 1'b0, 12'o0300, 31'h0, {20'h5A5A5, 11'o300});
    run_access("io_wr", 1'b1, 1'b1, 12'o0321, 31'h07654321, {20'h5A5A5, 11'o300});
    run_access("cpu_rd_io", 1'b0, 1'b0, 12'o0321, 31'h0, 31'h07654321);

    // Store never finishes.
    stall  = 1'b1;
    cpu_we = 1'b0; cpu_addr = 12'o0010; cpu_req = 1'b1;
    n = 0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    do begin
      tick;
      n++;
    end while (!cpu_ack && n < 40);
    chk("tmo_lat", n, 32'd16);
    chk("tmo_err", {31'd0, cpu_err}, 32'd1);
    chk("tmo_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    chk("tmo_rdata", {1'b0, cpu_rdata}, 32'd0);
    cpu_req = 1'b0;
    stall   = 1'b0;
    tick;
`else
    for (int c = 0; c < 40; c++) begin
      tick;
      if (cpu_ack) n++;
    end
    chk("wait_no_ack", n, 32'd0);
    chk("wait_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd2);
    stall = 1'b0;
    do_reset;
`endif
    run_access("final_rd", 1'b0, 1'b0, 12'o0123, 31'h0, 31'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
